// File: rtl/traffic_pkg.sv
// Shared road indexing and default sizing for the PIR vehicle-counter front end.
package traffic_pkg;

  localparam int ROAD_A    = 0;
  localparam int ROAD_B    = 1;
  localparam int ROAD_C    = 2;
  localparam int ROAD_D    = 3;
  localparam int NUM_ROADS = 4;

  localparam int DEFAULT_CNT_W       = 8;
  localparam int DEFAULT_MAX_COUNT   = 255;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef logic [1:0] road_idx_t;

endpackage

// File: rtl/pir_lane_counter.sv
// One road: sensor synchronisers, rising-edge detect, saturating vehicle count
// and the road's sticky overflow/underflow flags.
module pir_lane_counter
  import traffic_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int MAX_COUNT   = DEFAULT_MAX_COUNT,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pir_start,
  input  logic             pir_end,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_start_p0;
  logic [SYNC_STAGES-1:0] sync_end_p0;
  logic                   prev_start_p1;
  logic                   prev_end_p1;
  logic                   arr;
  logic                   dep;
  logic [CNT_W-1:0]       count_p2;
  logic [CNT_W-1:0]       count_next;
  logic                   ovf_set;
  logic                   unf_set;
  logic                   ovf_p2;
  logic                   unf_p2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= MAX_C) ? v : v + ONE_C;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - ONE_C;
  endfunction

  // Stage p0/p1: synchroniser output versus its previous value gives a
  // single-cycle pulse per rising edge, so a held level counts only once.
  assign arr = sync_start_p0[SYNC_STAGES-1] & ~prev_start_p1;
  assign dep = sync_end_p0[SYNC_STAGES-1]   & ~prev_end_p1;

  // Stage p2: simultaneous arrival and departure cancel with no error raised.
  always_comb begin
    count_next = count_p2;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    case ({arr, dep})
      2'b10: begin
        count_next = sat_inc(count_p2);
        ovf_set    = (count_p2 >= MAX_C);
      end
      2'b01: begin
        count_next = sat_dec(count_p2);
        unf_set    = (count_p2 == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_start_p0 <= '0;
      sync_end_p0   <= '0;
      prev_start_p1 <= 1'b0;
      prev_end_p1   <= 1'b0;
      count_p2      <= '0;
      ovf_p2        <= 1'b0;
      unf_p2        <= 1'b0;
    end else begin
      sync_start_p0 <= {sync_start_p0[SYNC_STAGES-2:0], pir_start};
      sync_end_p0   <= {sync_end_p0[SYNC_STAGES-2:0], pir_end};
      prev_start_p1 <= sync_start_p0[SYNC_STAGES-1];
      prev_end_p1   <= sync_end_p0[SYNC_STAGES-1];
      count_p2      <= count_next;
      // Set wins over a coincident clear so no event is ever lost.
      ovf_p2        <= ovf_set | (ovf_p2 & ~err_clr);
      unf_p2        <= unf_set | (unf_p2 & ~err_clr);
    end
  end

  assign count         = count_p2;
  assign overflow_err  = ovf_p2;
  assign underflow_err = unf_p2;

endmodule

// File: rtl/pir_vehicle_counter.sv
// Four-road PIR vehicle counter: per-road lanes plus the registered busiest-road
// argmax and occupancy flags handed to the signal scheduler.
module pir_vehicle_counter
  import traffic_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int MAX_COUNT   = DEFAULT_MAX_COUNT,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_ROADS-1:0] pir_start,
  input  logic [NUM_ROADS-1:0] pir_end,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     count_a,
  output logic [CNT_W-1:0]     count_b,
  output logic [CNT_W-1:0]     count_c,
  output logic [CNT_W-1:0]     count_d,
  output logic [NUM_ROADS-1:0] waiting,
  output logic [1:0]           busiest_road,
  output logic [NUM_ROADS-1:0] overflow_err,
  output logic [NUM_ROADS-1:0] underflow_err
);

  logic [CNT_W-1:0] counts [NUM_ROADS];
  road_idx_t        best_idx;
  logic [CNT_W-1:0] best_cnt;
  road_idx_t        busiest_p3;

  for (genvar r = 0; r < NUM_ROADS; r++) begin : g_lane
    pir_lane_counter #(
      .CNT_W       (CNT_W),
      .MAX_COUNT   (MAX_COUNT),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_lane (
      .clk           (clk),
      .reset         (reset),
      .pir_start     (pir_start[r]),
      .pir_end       (pir_end[r]),
      .err_clr       (err_clr),
      .count         (counts[r]),
      .overflow_err  (overflow_err[r]),
      .underflow_err (underflow_err[r])
    );
  end

  assign count_a = counts[ROAD_A];
  assign count_b = counts[ROAD_B];
  assign count_c = counts[ROAD_C];
  assign count_d = counts[ROAD_D];

  // Decoded straight from the count flops so it changes on the same edge.
  always_comb begin
    waiting = '0;
    for (int r = 0; r < NUM_ROADS; r++) begin
      waiting[r] = (counts[r] != '0);
    end
  end

  // Strict greater-than keeps the lowest index on ties and road A when all are zero.
  always_comb begin
    best_idx = road_idx_t'(ROAD_A);
    best_cnt = counts[ROAD_A];
    for (int r = 1; r < NUM_ROADS; r++) begin
      if (counts[r] > best_cnt) begin
        best_idx = road_idx_t'(r);
        best_cnt = counts[r];
      end
    end
  end

  // Stage p3: argmax registered one edge after the counts it was built from.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busiest_p3 <= '0;
    end else begin
      busiest_p3 <= best_idx;
    end
  end

  assign busiest_road = busiest_p3;

endmodule
